// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate generator and anything else in the
// decode stage that needs to agree on the imm_src encoding.
//   XLEN_DEFAULT   : default datapath width (32 or 64)
//   INSTR_HI_W     : width of the instr_hi bus (instruction bits [31:7])
//   IMM_*          : imm_src format codes; IMM_RSV is the reserved code
// ---------------------------------------------------------------------------
package imm_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_HI_W   = 25;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Combinational immediate extraction and extension for the eight imm_src
// formats. Sits directly ahead of the first register slice.
// Ports:
//   instr_hi [24:0]   in   instruction bits [31:7] (bit k = instruction bit k+7)
//   imm_src  [2:0]    in   format select (IMM_* codes from imm_pkg)
//   imm      [XLEN-1:0] out extended immediate (0 for the reserved code)
//   illegal           out  high when imm_src is the reserved code
// ---------------------------------------------------------------------------
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [INSTR_HI_W-1:0] instr_hi,
    input  logic [2:0]            imm_src,
    output logic [XLEN-1:0]       imm,
    output logic                  illegal
);

    // Re-index the bus so the field slices below read like the ISA manual.
    logic [31:7] ins;
    assign ins = instr_hi;

    // Each signed field is assembled at its natural width; the sized cast to
    // XLEN below then replicates its top bit.
    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;
    logic signed [31:0] u_imm;

    assign i_imm = ins[31:20];
    assign s_imm = {ins[31:25], ins[11:7]};
    assign b_imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign j_imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign u_imm = {ins[31:12], 12'b0};

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:  imm = XLEN'(i_imm);
            IMM_S:  imm = XLEN'(s_imm);
            IMM_B:  imm = XLEN'(b_imm);
            IMM_J:  imm = XLEN'(j_imm);
            IMM_U:  imm = XLEN'(u_imm);
            IMM_Z:  imm = XLEN'(ins[19:15]);
            IMM_SH: begin
                // RV64 shift amounts carry one extra bit (ins[25]).
                if (XLEN == 64) begin
                    imm = XLEN'(ins[25:20]);
                end else begin
                    imm = XLEN'(ins[24:20]);
                end
            end
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator: combinational decode followed by STAGES
// register slices with a valid/ready handshake, flush and synchronous reset.
// Ports:
//   clk               in   rising-edge clock
//   reset             in   synchronous, active-high; clears every slice
//   in_valid          in   instr_hi/imm_src valid
//   in_ready          out  block can accept this cycle (combinational from out_ready)
//   instr_hi [24:0]   in   instruction bits [31:7]
//   imm_src  [2:0]    in   format select
//   flush             in   drop every in-flight entry at the next edge
//   out_valid         out  imm_out/illegal valid
//   out_ready         in   consumer accepts this cycle
//   imm_out [XLEN-1:0] out extended immediate
//   illegal           out  entry carried the reserved imm_src code
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int STAGES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_HI_W-1:0] instr_hi,
    input  logic [2:0]            imm_src,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       imm_out,
    output logic                  illegal
);

    localparam int LAST = STAGES - 1;

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr_hi(instr_hi),
        .imm_src (imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // A slice accepts when it is empty or its downstream neighbour accepts in
    // the same cycle. The accept chain runs combinationally from out_ready
    // back to in_ready, which is what lets a full pipe move every cycle.
    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        logic            vld;
        logic [XLEN-1:0] imm;
        logic            ill;
        logic            accept;

        logic            up_vld;
        logic [XLEN-1:0] up_imm;
        logic            up_ill;
        logic            down_accept;

        if (i == 0) begin : g_from_decode
            assign up_vld = in_valid;
            assign up_imm = dec_imm;
            assign up_ill = dec_illegal;
        end else begin : g_from_prev
            assign up_vld = g_slice[i-1].vld;
            assign up_imm = g_slice[i-1].imm;
            assign up_ill = g_slice[i-1].ill;
        end

        if (i == LAST) begin : g_to_out
            assign down_accept = out_ready;
        end else begin : g_to_next
            assign down_accept = g_slice[i+1].accept;
        end

        assign accept = !vld || down_accept;

        // Slice register boundary
        always_ff @(posedge clk) begin
            if (reset) begin
                vld <= 1'b0;
                imm <= '0;
                ill <= 1'b0;
            end else begin
                // On accept the valid bit always follows upstream, so an
                // empty upstream slot moves down as a bubble instead of the
                // current entry being kept (and later re-presented).
                if (flush) begin
                    vld <= 1'b0;
                end else if (accept) begin
                    vld <= up_vld;
                end
                // Data only moves with a real entry, so an emptied output
                // slice keeps showing its last immediate.
                if (accept && up_vld) begin
                    imm <= up_imm;
                    ill <= up_ill;
                end
            end
        end
    end

    assign in_ready  = g_slice[0].accept;
    assign out_valid = g_slice[LAST].vld;
    assign imm_out   = g_slice[LAST].imm;
    assign illegal   = g_slice[LAST].ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
// Two instances: dut_a (XLEN=32, STAGES=1) and dut_b (XLEN=64, STAGES=2).
// Expected immediates come from a shift/mask reference model and from fixed
// constants; accepted entries are queued and popped as the DUT emits them.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_illegal;
    logic [24:0] a_instr_hi;
    logic [2:0]  a_imm_src;
    logic [31:0] a_imm_out;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_illegal;
    logic [24:0] b_instr_hi;
    logic [2:0]  b_imm_src;
    logic [63:0] b_imm_out;

    int checks   = 0;
    int failures = 0;

    imm_gen_pipe #(.XLEN(32), .STAGES(1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .instr_hi(a_instr_hi), .imm_src(a_imm_src), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .imm_out(a_imm_out), .illegal(a_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(2)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .instr_hi(b_instr_hi), .imm_src(b_imm_src), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .imm_out(b_imm_out), .illegal(b_illegal)
    );

    // Reference model: {illegal, imm[63:0]}, built from arithmetic shifts
    // of the sign-extended instruction word plus masks.
    function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
        logic signed [63:0] s;
        logic [63:0] sh20, sgn, v;
        logic ill;
        s    = {{32{ins[31]}}, ins};
        sh20 = s >>> 20;
        sgn  = s >>> 31;
        ill  = 1'b0;
        case (src)
            3'd0: v = sh20;
            3'd1: v = (sh20 & ~64'h1F) | 64'(ins[11:7]);
            3'd2: v = (sgn & ~64'hFFF) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                      | (64'(ins[11:8]) << 1);
            3'd3: v = (sgn & ~64'hFFFFF) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                      | (64'(ins[30:21]) << 1);
            3'd4: v = s & ~64'hFFF;
            3'd5: v = 64'(ins[19:15]);
            3'd6: v = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
            default: begin
                v   = '0;
                ill = 1'b1;
            end
        endcase
        if (xlen == 32) v[63:32] = '0;
        return {ill, v};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_illegal} !== 2'b00 || a_imm_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_a: out_valid=%b illegal=%b imm=%h, required 0 0 0",
                     a_out_valid, a_illegal, a_imm_out);
        end
        checks++;
        if ({b_out_valid, b_illegal} !== 2'b00 || b_imm_out !== 64'h0) begin
            failures++;
            $display("FAIL reset_b: out_valid=%b illegal=%b imm=%h, required 0 0 0",
                     b_out_valid, b_illegal, b_imm_out);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_formats_a();
        logic [31:0] vi[$];
        logic [2:0]  vs[$];
        logic [64:0] q[$];
        logic [64:0] e;
        int k = 0, n_out = 0, run = 0, max_run = 0;
        vi = '{32'hFFF00093, 32'hFE000EE3, 32'h001000EF, 32'h300FD073, 32'h12345678, 32'hFFF00093};
        vs = '{IMM_I, IMM_B, IMM_J, IMM_Z, IMM_RSV, IMM_I};
        for (int j = 0; j < 10; j++) begin
            vi.push_back($urandom);
            vs.push_back(3'($urandom_range(0, 7)));
        end
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < vi.size() + 4; cyc++) begin
            if (k < vi.size()) begin
                a_in_valid = 1'b1;
                a_instr_hi = vi[k][31:7];
                a_imm_src  = vs[k];
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clk);
            if (a_out_valid && a_out_ready) begin
                n_out++;
                run++;
                if (run > max_run) max_run = run;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL fmt_a_extra: imm=%h appeared with nothing pending", a_imm_out);
                end else begin
                    e = q.pop_front();
                    if (a_imm_out !== e[31:0] || a_illegal !== e[64]) begin
                        failures++;
                        $display("FAIL fmt_a_out: got imm=%h ill=%b, required imm=%h ill=%b",
                                 a_imm_out, a_illegal, e[31:0], e[64]);
                    end
                end
            end else begin
                run = 0;
            end
            if (a_in_valid && a_in_ready) begin
                q.push_back(model(vi[k], vs[k], 32));
                k++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_out != vi.size() || max_run != vi.size()) begin
            failures++;
            $display("FAIL fmt_a_b2b: outputs=%0d longest_run=%0d, required %0d and %0d",
                     n_out, max_run, vi.size(), vi.size());
        end
    endtask

    task automatic test_formats_b();
        logic [31:0] vi[$];
        logic [2:0]  vs[$];
        logic [64:0] q[$];
        logic [64:0] e;
        int k = 0, n_out = 0, run = 0, max_run = 0;
        vi = '{32'h800002B7, 32'h03F01013, 32'hFE000EE3, 32'h300FD073, 32'hABCDE123};
        vs = '{IMM_U, IMM_SH, IMM_B, IMM_Z, IMM_RSV};
        for (int j = 0; j < 16; j++) begin
            vi.push_back($urandom);
            vs.push_back(3'(j % 8));
        end
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < vi.size() + 5; cyc++) begin
            if (k < vi.size()) begin
                b_in_valid = 1'b1;
                b_instr_hi = vi[k][31:7];
                b_imm_src  = vs[k];
            end else begin
                b_in_valid = 1'b0;
            end
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                n_out++;
                run++;
                if (run > max_run) max_run = run;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL fmt_b_extra: imm=%h appeared with nothing pending", b_imm_out);
                end else begin
                    e = q.pop_front();
                    if (b_imm_out !== e[63:0] || b_illegal !== e[64]) begin
                        failures++;
                        $display("FAIL fmt_b_out: got imm=%h ill=%b, required imm=%h ill=%b",
                                 b_imm_out, b_illegal, e[63:0], e[64]);
                    end
                end
            end else begin
                run = 0;
            end
            if (b_in_valid && b_in_ready) begin
                q.push_back(model(vi[k], vs[k], 64));
                k++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_out != vi.size() || max_run != vi.size()) begin
            failures++;
            $display("FAIL fmt_b_b2b: outputs=%0d longest_run=%0d, required %0d and %0d",
                     n_out, max_run, vi.size(), vi.size());
        end
    endtask

    task automatic test_backpressure_b();
        logic [63:0] ev[3];
        ev[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        ev[1] = 64'hFFFF_FFFF_8000_0000;
        ev[2] = 64'h0000_0000_0000_003F;
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_instr_hi  = 25'(32'hFFF00093 >> 7);
        b_imm_src   = IMM_I;
        @(negedge clk);
        checks++;
        if (b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_empty_ready: in_ready=%b, required 1", b_in_ready);
        end
        @(posedge clk);
        #1;
        b_instr_hi = 25'(32'h800002B7 >> 7);
        b_imm_src  = IMM_U;
        @(negedge clk);
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_one_entry: in_ready=%b out_valid=%b, required 1 0",
                     b_in_ready, b_out_valid);
        end
        @(posedge clk);
        #1;
        b_instr_hi = 25'(32'h03F01013 >> 7);
        b_imm_src  = IMM_SH;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 || b_imm_out !== ev[0]) begin
                failures++;
                $display("FAIL bp_full_hold: in_ready=%b out_valid=%b imm=%h, required 0 1 %h",
                         b_in_ready, b_out_valid, b_imm_out, ev[0]);
            end
            @(posedge clk);
            #1;
        end
        b_out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) begin
                checks++;
                if (b_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_ready_same_cycle: in_ready=%b, required 1", b_in_ready);
                end
            end
            checks++;
            if (b_out_valid !== 1'b1 || b_imm_out !== ev[j] || b_illegal !== 1'b0) begin
                failures++;
                $display("FAIL bp_drain_%0d: out_valid=%b imm=%h ill=%b, required 1 %h 0",
                         j, b_out_valid, b_imm_out, b_illegal, ev[j]);
            end
            @(posedge clk);
            #1;
            if (j == 0) b_in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty_after: out_valid=%b, required 0", b_out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush_b();
        int first = -1;
        int extra = 0;
        logic [63:0] got = '0;
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_instr_hi  = 25'(32'h001000EF >> 7);
        b_imm_src   = IMM_J;
        @(posedge clk);
        #1;
        b_instr_hi = 25'(32'hFFF00093 >> 7);
        b_imm_src  = IMM_I;
        @(posedge clk);
        #1;
        b_instr_hi  = 25'(32'h800002B7 >> 7);
        b_imm_src   = IMM_U;
        b_flush     = 1'b1;
        b_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b1 || b_imm_out !== 64'h800 || b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre: out_valid=%b imm=%h in_ready=%b, required 1 800 1",
                     b_out_valid, b_imm_out, b_in_ready);
        end
        @(posedge clk);
        #1;
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: out_valid=%b, required 0", b_out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL flush_ghost: %0d outputs after flush, required 0", extra);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_instr_hi = 25'(32'h300FD073 >> 7);
        b_imm_src  = IMM_Z;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (b_out_valid && first < 0) begin
                first = c;
                got   = b_imm_out;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (first != 2 || got !== 64'h1F) begin
            failures++;
            $display("FAIL flush_resume: latency=%0d imm=%h, required 2 %h", first, got, 64'h1F);
        end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_instr_hi  = 25'(32'h5A5A5A5A >> 7);
        a_imm_src   = IMM_RSV;
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_instr_hi  = 25'(32'hFFF00093 >> 7);
        b_imm_src   = IMM_I;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        b_instr_hi = 25'(32'hFE000EE3 >> 7);
        b_imm_src  = IMM_B;
        @(posedge clk);
        #1;
        b_instr_hi = 25'(32'h001000EF >> 7);
        b_imm_src  = IMM_J;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_illegal !== 1'b1 || b_out_valid !== 1'b1
            || b_imm_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL rst_mid_pre: a_vld=%b a_ill=%b b_vld=%b b_imm=%h, required 1 1 1 ffffffffffffffff",
                     a_out_valid, a_illegal, b_out_valid, b_imm_out);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_illegal} !== 2'b00 || a_imm_out !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_a: out_valid=%b illegal=%b imm=%h, required 0 0 0",
                     a_out_valid, a_illegal, a_imm_out);
        end
        checks++;
        if ({b_out_valid, b_illegal} !== 2'b00 || b_imm_out !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid_b: out_valid=%b illegal=%b imm=%h, required 0 0 0",
                     b_out_valid, b_illegal, b_imm_out);
        end
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ready: a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (b_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_ghost: out_valid=%b on cycle %0d, required 0", b_out_valid, c);
            end
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
    endtask

    task automatic test_random_b();
        logic [64:0] q[$];
        logic [64:0] e;
        logic [31:0] cur_i = '0;
        logic [2:0]  cur_s = '0;
        logic stalled = 1'b0;
        for (int cyc = 0; cyc < 128; cyc++) begin
            if (!stalled) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                cur_i      = $urandom;
                cur_s      = 3'($urandom_range(0, 7));
                b_instr_hi = cur_i[31:7];
                b_imm_src  = cur_s;
            end
            b_out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra: imm=%h appeared with nothing pending", b_imm_out);
                end else begin
                    e = q.pop_front();
                    if (b_imm_out !== e[63:0] || b_illegal !== e[64]) begin
                        failures++;
                        $display("FAIL rand_out: got imm=%h ill=%b, required imm=%h ill=%b",
                                 b_imm_out, b_illegal, e[63:0], e[64]);
                    end
                end
            end
            if (b_in_valid && b_in_ready) q.push_back(model(cur_i, cur_s, 64));
            stalled = b_in_valid && !b_in_ready;
            @(posedge clk);
            #1;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (b_out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_drain_extra: imm=%h appeared with nothing pending", b_imm_out);
                end else begin
                    e = q.pop_front();
                    if (b_imm_out !== e[63:0] || b_illegal !== e[64]) begin
                        failures++;
                        $display("FAIL rand_drain: got imm=%h ill=%b, required imm=%h ill=%b",
                                 b_imm_out, b_illegal, e[63:0], e[64]);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rand_lost: %0d entries never emerged, required 0", q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0;
        a_instr_hi  = '0;
        a_imm_src   = '0;
        a_flush     = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_instr_hi  = '0;
        b_imm_src   = '0;
        b_flush     = 1'b0;
        b_out_ready = 1'b0;

        test_reset();
        test_formats_a();
        test_formats_b();
        test_backpressure_b();
        test_flush_b();
        test_reset_mid();
        test_random_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
